// File: rtl/nfu_2_accum_if.sv
// nfu_2_accum_if: product-tile input bus and result output bus of the NFU-2 stage.
interface nfu_2_accum_if #(
  parameter int unsigned N  = 16,
  parameter int unsigned TN = 16
);
  logic                  i_valid;
  logic                  i_first;
  logic                  i_last;
  logic [N*TN*TN-1:0]    i_products;
  logic                  o_valid;
  logic [N*TN-1:0]       o_sums;
  logic [7:0]            o_tile_cnt;
  logic                  o_busy;
  logic                  o_err;

  // Producer side (controller / multiplier stage and result consumer)
  modport master (
    output i_valid, i_first, i_last, i_products,
    input  o_valid, o_sums, o_tile_cnt, o_busy, o_err
  );

  // Accumulator block side
  modport slave (
    input  i_valid, i_first, i_last, i_products,
    output o_valid, o_sums, o_tile_cnt, o_busy, o_err
  );
endinterface

// File: rtl/nfu_2_accum.sv
// nfu_2_accum: reduces each row of a TN x TN product tile through a two-stage
// pipelined adder tree and accumulates row sums across tiles (S0..S3).
// Optional feature macro: NFU2_SATURATE_EN (clamp emitted values instead of truncating).
module nfu_2_accum #(
  parameter int unsigned N  = 16,
  parameter int unsigned TN = 16
) (
  input  logic           clk,
  input  logic           rst,
  nfu_2_accum_if.slave   bus
);
  localparam int unsigned L     = $clog2(TN);
  localparam int unsigned L1    = (L + 1) / 2;
  localparam int unsigned S1CNT = TN >> L1;
  localparam int unsigned W     = N + L;
  localparam int unsigned AW    = 2 * N;
  localparam int unsigned CW    = 8;

  typedef enum logic {ST_IDLE = 1'b0, ST_ACCUM = 1'b1} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_s0_valid, r_s0_first, r_s0_last;
  logic [N*TN*TN-1:0]    r_s0_prod;
  logic                  r_s1_valid, r_s1_first, r_s1_last;
  logic signed [W-1:0]   r_s1_sum [TN][S1CNT];
  logic                  r_s2_valid, r_s2_first, r_s2_last;
  logic signed [W-1:0]   r_s2_sum [TN];
  logic signed [AW-1:0]  r_acc [TN];
  logic [CW-1:0]         r_cnt;
  logic                  r_valid, r_busy, r_err;
  logic [N*TN-1:0]       r_sums;
  logic [CW-1:0]         r_tile_cnt;

  logic signed [W-1:0]   w_s1_sum [TN][S1CNT];
  logic signed [W-1:0]   w_s2_sum [TN];
  logic signed [AW-1:0]  w_acc_nxt [TN];
  logic                  w_load, w_add, w_emit, w_err_set;
  logic [CW-1:0]         w_cnt_nxt;

`ifdef NFU2_SATURATE_EN
  localparam logic signed [AW-1:0] SAT_HI = {{(AW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_LO = {{(AW-N+1){1'b1}}, {(N-1){1'b0}}};
`endif

  // Convert a wide accumulator to an N-bit output lane
  function automatic logic [N-1:0] conv(input logic signed [AW-1:0] a);
`ifdef NFU2_SATURATE_EN
    if (a > SAT_HI)      conv = N'(SAT_HI);
    else if (a < SAT_LO) conv = N'(SAT_LO);
    else                 conv = N'(a);
`else
    conv = N'(a);
`endif
  endfunction

  // S0 valid/flag capture; beats presented during reset are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0_valid <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s0_valid <= bus.i_valid;
      r_s1_valid <= r_s0_valid;
      r_s2_valid <= r_s1_valid;
    end
  end

  // Pipeline payload registers (qualified by the valid bits above)
  always_ff @(posedge clk) begin
    r_s0_first <= bus.i_first;
    r_s0_last  <= bus.i_last;
    r_s0_prod  <= bus.i_products;
    r_s1_first <= r_s0_first;
    r_s1_last  <= r_s0_last;
    r_s1_sum   <= w_s1_sum;
    r_s2_first <= r_s1_first;
    r_s2_last  <= r_s1_last;
    r_s2_sum   <= w_s2_sum;
  end

  // First tree half: sign-extend products and reduce L1 levels per row
  always_comb begin : s1_tree
    logic signed [W-1:0] t [TN];
    for (int r = 0; r < int'(TN); r++) begin
      for (int i = 0; i < int'(TN); i++)
        t[i] = W'($signed(r_s0_prod[(r*int'(TN)+i)*int'(N) +: N]));
      for (int lv = 0; lv < int'(L1); lv++)
        for (int i = 0; i < int'(TN >> (lv + 1)); i++)
          t[i] = t[2*i] + t[2*i+1];
      for (int i = 0; i < int'(S1CNT); i++)
        w_s1_sum[r][i] = t[i];
    end
  end

  // Second tree half: reduce the remaining partials to one sum per row
  always_comb begin : s2_tree
    logic signed [W-1:0] t [S1CNT];
    for (int r = 0; r < int'(TN); r++) begin
      for (int i = 0; i < int'(S1CNT); i++)
        t[i] = r_s1_sum[r][i];
      for (int c = int'(S1CNT); c > 1; c = c / 2)
        for (int i = 0; i < c / 2; i++)
          t[i] = t[2*i] + t[2*i+1];
      w_s2_sum[r] = t[0];
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state and S3 control decisions for the beat leaving S2
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_add       = 1'b0;
    w_emit      = 1'b0;
    w_err_set   = 1'b0;
    w_cnt_nxt   = r_cnt;
    if (r_s2_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (r_s2_first) begin
            w_load      = 1'b1;
            w_cnt_nxt   = CW'(1);
            w_emit      = r_s2_last;
            w_state_nxt = r_s2_last ? ST_IDLE : ST_ACCUM;
          end else begin
            w_err_set   = 1'b1;
          end
        end
        ST_ACCUM: begin
          if (r_s2_first) begin
            w_err_set = 1'b1;
            w_load    = 1'b1;
            w_cnt_nxt = CW'(1);
          end else begin
            w_add     = 1'b1;
            w_cnt_nxt = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + CW'(1);
          end
          w_emit      = r_s2_last;
          w_state_nxt = r_s2_last ? ST_IDLE : ST_ACCUM;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Post-update accumulator values, also the source of emitted lanes
  always_comb begin
    for (int r = 0; r < int'(TN); r++) begin
      if (w_load)     w_acc_nxt[r] = AW'(r_s2_sum[r]);
      else if (w_add) w_acc_nxt[r] = r_acc[r] + AW'(r_s2_sum[r]);
      else            w_acc_nxt[r] = r_acc[r];
    end
  end

  // S3: accumulators, tile count and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < int'(TN); r++) r_acc[r] <= '0;
      r_cnt      <= '0;
      r_valid    <= 1'b0;
      r_sums     <= '0;
      r_tile_cnt <= '0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_emit;
      if (w_emit) begin
        for (int r = 0; r < int'(TN); r++) r_sums[r*int'(N) +: N] <= conv(w_acc_nxt[r]);
        r_tile_cnt <= w_cnt_nxt;
      end
      r_busy <= (w_state_nxt == ST_ACCUM) | bus.i_valid | r_s0_valid | r_s1_valid;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign bus.o_valid    = r_valid;
  assign bus.o_sums     = r_sums;
  assign bus.o_tile_cnt = r_tile_cnt;
  assign bus.o_busy     = r_busy;
  assign bus.o_err      = r_err;
endmodule

// File: tb/tb_nfu_2_accum.sv
// tb_nfu_2_accum: directed bench for nfu_2_accum (N=16, TN=16).
module tb_nfu_2_accum;
  localparam int unsigned N  = 16;
  localparam int unsigned TN = 16;
  localparam int unsigned PW = N * TN * TN;
  localparam int unsigned SW = N * TN;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ntests = 0;
  int   nfail  = 0;
  int   vcount = 0;
  int   vsave;

  nfu_2_accum_if #(.N(N), .TN(TN)) bus ();

  nfu_2_accum #(.N(N), .TN(TN)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Count result pulses between edges
  always @(negedge clk) if (bus.o_valid === 1'b1) vcount++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [PW-1:0] prod_all(input logic [N-1:0] v);
    logic [PW-1:0] p;
    for (int i = 0; i < int'(TN*TN); i++) p[i*N +: N] = v;
    return p;
  endfunction

  function automatic logic [PW-1:0] prod_rowm1();
    logic [PW-1:0] p;
    for (int r = 0; r < int'(TN); r++)
      for (int i = 0; i < int'(TN); i++) p[(r*TN+i)*N +: N] = N'(r - 1);
    return p;
  endfunction

  function automatic logic [PW-1:0] prod_first(input logic [N-1:0] v);
    logic [PW-1:0] p;
    p = '0;
    for (int r = 0; r < int'(TN); r++) p[(r*TN)*N +: N] = v;
    return p;
  endfunction

  function automatic logic [SW-1:0] lanes_all(input logic [N-1:0] v);
    logic [SW-1:0] s;
    for (int r = 0; r < int'(TN); r++) s[r*N +: N] = v;
    return s;
  endfunction

  function automatic logic [SW-1:0] lanes_rowm1x48();
    logic [SW-1:0] s;
    for (int r = 0; r < int'(TN); r++) s[r*N +: N] = N'(48 * (r - 1));
    return s;
  endfunction

  task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic f, input logic l, input logic [PW-1:0] p);
    bus.i_valid    = 1'b1;
    bus.i_first    = f;
    bus.i_last     = l;
    bus.i_products = p;
    step();
    bus.i_valid    = 1'b0;
    bus.i_first    = 1'b0;
    bus.i_last     = 1'b0;
  endtask

  initial begin
    logic [SW-1:0] exp_sat;
    bus.i_valid    = 1'b0;
    bus.i_first    = 1'b0;
    bus.i_last     = 1'b0;
    bus.i_products = '0;

    // Reset values
    step(); step();
    chk("rst_valid", SW'(bus.o_valid), SW'(0));
    chk("rst_sums",  bus.o_sums, '0);
    chk("rst_cnt",   SW'(bus.o_tile_cnt), SW'(0));
    chk("rst_busy",  SW'(bus.o_busy), SW'(0));
    chk("rst_err",   SW'(bus.o_err), SW'(0));
    rst = 1'b0;
    step();

    // Single first+last beat of all ones
    beat(1'b1, 1'b1, prod_all(16'd1));
    step();
    chk("one_busy",   SW'(bus.o_busy), SW'(1));
    step();
    chk("one_early",  SW'(bus.o_valid), SW'(0));
    step();
    chk("one_valid",  SW'(bus.o_valid), SW'(1));
    chk("one_sums",   bus.o_sums, lanes_all(16'd16));
    chk("one_cnt",    SW'(bus.o_tile_cnt), SW'(1));
    chk("one_err",    SW'(bus.o_err), SW'(0));
    step();
    chk("one_pulse",  SW'(bus.o_valid), SW'(0));
    chk("one_hold",   bus.o_sums, lanes_all(16'd16));

    // Back-to-back single-tile accumulations
    beat(1'b1, 1'b1, prod_all(16'd1));
    beat(1'b1, 1'b1, prod_all(16'd3));
    step(); step();
    chk("b2b_v0",  SW'(bus.o_valid), SW'(1));
    chk("b2b_s0",  bus.o_sums, lanes_all(16'd16));
    step();
    chk("b2b_v1",  SW'(bus.o_valid), SW'(1));
    chk("b2b_s1",  bus.o_sums, lanes_all(16'd48));
    step();

    // Three tiles with a two-cycle bubble before the last one
    vsave = vcount;
    beat(1'b1, 1'b0, prod_rowm1());
    beat(1'b0, 1'b0, prod_rowm1());
    step(); step();
    beat(1'b0, 1'b1, prod_rowm1());
    step(); step();
    chk("tri_early", SW'(bus.o_valid), SW'(0));
    step();
    chk("tri_valid", SW'(bus.o_valid), SW'(1));
    chk("tri_sums",  bus.o_sums, lanes_rowm1x48());
    chk("tri_cnt",   SW'(bus.o_tile_cnt), SW'(3));
    chk("tri_idle",  SW'(bus.o_busy), SW'(0));
    step();
    chk("tri_once",  SW'(vcount - vsave), SW'(1));

    // Large positive accumulation: clamp or wrap on output
`ifdef NFU2_SATURATE_EN
    exp_sat = lanes_all(16'h7FFF);
`else
    exp_sat = lanes_all(16'hFFE0);
`endif
    beat(1'b1, 1'b0, prod_all(16'h7FFF));
    beat(1'b0, 1'b1, prod_all(16'h7FFF));
    step(); step(); step();
    chk("big_valid", SW'(bus.o_valid), SW'(1));
    chk("big_sums",  bus.o_sums, exp_sat);
    chk("big_cnt",   SW'(bus.o_tile_cnt), SW'(2));
    step();

    // Continuation beat while idle is dropped and flagged
    vsave = vcount;
    beat(1'b0, 1'b1, prod_all(16'd1));
    step(); step(); step(); step();
    chk("drop_novalid", SW'(vcount - vsave), SW'(0));
    chk("drop_err",     SW'(bus.o_err), SW'(1));
    chk("drop_hold",    bus.o_sums, exp_sat);
    chk("drop_cnt",     SW'(bus.o_tile_cnt), SW'(2));
    beat(1'b1, 1'b1, prod_all(16'd2));
    step(); step(); step();
    chk("rec_valid", SW'(bus.o_valid), SW'(1));
    chk("rec_sums",  bus.o_sums, lanes_all(16'd32));
    chk("rec_cnt",   SW'(bus.o_tile_cnt), SW'(1));
    chk("rec_err",   SW'(bus.o_err), SW'(1));
    step();

    // Reset clears sticky error; then a restart inside an open accumulation
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("clr_err", SW'(bus.o_err), SW'(0));
    beat(1'b1, 1'b0, prod_first(16'd100));
    beat(1'b1, 1'b1, prod_first(16'd5));
    step(); step(); step();
    chk("rest_valid", SW'(bus.o_valid), SW'(1));
    chk("rest_sums",  bus.o_sums, lanes_all(16'd5));
    chk("rest_err",   SW'(bus.o_err), SW'(1));
    chk("rest_cnt",   SW'(bus.o_tile_cnt), SW'(1));
    step();

    // Reset two cycles after a first+last beat; a beat during reset is ignored
    vsave = vcount;
    beat(1'b1, 1'b1, prod_all(16'd1));
    step();
    rst = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_first = 1'b1;
    bus.i_last  = 1'b1;
    step();
    rst = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_first = 1'b0;
    bus.i_last  = 1'b0;
    chk("mid_valid", SW'(bus.o_valid), SW'(0));
    chk("mid_sums",  bus.o_sums, '0);
    chk("mid_cnt",   SW'(bus.o_tile_cnt), SW'(0));
    chk("mid_busy",  SW'(bus.o_busy), SW'(0));
    chk("mid_err",   SW'(bus.o_err), SW'(0));
    step(); step(); step(); step();
    chk("mid_lost",  SW'(vcount - vsave), SW'(0));
    chk("mid_idle",  SW'(bus.o_busy), SW'(0));

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/nfu_2_accum.md
# nfu_2_accum

Second NFU stage: consumes the Tn x Tn product matrix from the multiplier stage, reduces each row of Tn products through a pipelined adder tree, and accumulates the per-row sums across successive input tiles into Tn output-neuron partial sums. It emits one Tn-wide result vector per completed accumulation, first-to-last tile, toward the activation/NFU-3 stage. The controller aligns the valid, first and last flags with the product vector; this block performs no realignment.

## Interface
- N, 16, data width of each product and each output value (signed two's complement)
- Tn, 16, products per row = number of output neurons; power of two, 4 to 64
- TnxTn, 256, Tn*Tn, width multiplier of i_products
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- i_valid  input  1  i_products/i_first/i_last are valid this cycle
- i_first  input  1  beat is the first tile of a new accumulation
- i_last  input  1  beat is the last tile; result is emitted
- i_products  input  N*TnxTn  row-major; row r (bits (r+1)*Tn*N-1 : r*Tn*N) holds the Tn products for output neuron r
- o_valid  output  1  single-cycle pulse; o_sums holds a new result
- o_sums  output  N*Tn  Tn results; neuron r at bits (r+1)*N-1 : r*N
- o_tile_cnt  output  8  tiles folded into the current or last-emitted accumulation
- o_busy  output  1  accumulation open (state ACCUM) or beat in flight
- o_err  output  1  sticky protocol-error flag

## Operation
- Pipeline S0 to S3, all registered:
  - S0: capture inputs and flags.
  - S1: tree levels 1 to ceil(L/2).
  - S2: remaining levels, where L = log2(Tn).
  - S3: accumulate and output.
- Tree arithmetic: sign-extend products to N+L bits; the tree is exact, with no overflow possible.
- Accumulator: one per row, 2N bits signed, wraps modulo 2^(2N).
  - first beat: acc <= tree_sum (sign-extended).
  - other beats: acc <= acc + tree_sum.
- State machine, evaluated at S3 on valid beats:
  - IDLE, beat with first=1: load acc, tile_cnt <= 1, go to ACCUM. If last=1 on the same beat, emit and stay IDLE.
  - IDLE, beat with first=0: beat dropped, o_err set, acc and tile_cnt unchanged.
  - ACCUM, beat with first=0: add, tile_cnt++ (saturates at 255). If last=1, emit and go to IDLE.
  - ACCUM, beat with first=1: previous partial discarded, o_err set, acc reloaded, tile_cnt <= 1. The last flag is handled as above.
- Emit: o_sums is computed from the post-update acc (see Configuration), o_valid pulses for one cycle, and o_sums and o_tile_cnt hold until the next emit or reset.
- Cycles with i_valid=0 insert bubbles and do not change the accumulators. Gaps of any length between tiles are legal.
- o_busy = (state==ACCUM) | any of S0 to S2 holding a valid beat.

## Timing
- Throughput: one beat per cycle, with no backpressure.
- Latency: a beat with i_valid=1 sampled at edge k updates acc at edge k+3. If last=1, o_valid is high in the cycle following edge k+3, i.e. 4 cycles after the input cycle.
- Back-to-back first+last beats produce o_valid on consecutive cycles.
- Reset values: o_valid=0, o_sums=0, o_tile_cnt=0, o_busy=0, o_err=0, state IDLE, pipeline valid bits 0, accumulators 0.
- Reset mid-operation: all in-flight beats are lost and the above values apply the cycle after the reset edge. o_err clears only on rst.
- A valid beat presented in the cycle rst is high is ignored.

## Configuration
- NFU2_SATURATE_EN defined: each emitted value is the 2N-bit acc clamped to [-2^(N-1), 2^(N-1)-1].
- NFU2_SATURATE_EN undefined: each emitted value is acc[N-1:0], wrap-around truncation.
- Accumulator behaviour is identical in both builds; only the output conversion differs.

## Test plan
- All products 1, a single beat with first=last=1 → o_valid 4 cycles later, every o_sums lane 16 (Tn=16), o_tile_cnt=1.
- Three tiles (first, middle, last) with row r products all r-1, then a 2-cycle bubble before last → lane r = 3*16*(r-1); o_valid exactly once, 4 cycles after the last beat; o_tile_cnt=3.
- Products all 0x7FFF over 2 tiles → acc 32*32767 = 1048544.
  - With NFU2_SATURATE_EN: lanes 0x7FFF.
  - Without it: lanes 0xFFE0.
- A beat with first=0 while IDLE → no o_valid, o_err=1 and held. A following valid first+last beat still produces a correct result.
- A first beat during ACCUM (acc holding 100) with products summing 5, last=1 → o_sums lane 5, o_err=1, o_tile_cnt=1.
- rst asserted 2 cycles after a first+last beat → no o_valid, all outputs 0 the cycle after the reset edge, o_busy=0.
